// File: rtl/seg_display_mux.sv
// Binary-to-BCD seven-segment display driver with time-multiplexed common-anode scan.
// Optional leading-zero blanking is enabled by defining SEG_DISPLAY_LEAD_BLANK_EN.
module seg_display_mux #(
   parameter int DIGITS      = 4,
   parameter int WIDTH       = 14,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  value,
   input  logic [DIGITS-1:0] dp_in,
   output logic              busy,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              dp
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [3:0] DASH = 4'hA;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_shift;
   logic [WIDTH-1:0]  r_last;
   logic [BW-1:0]     r_bcd;
   logic [BW-1:0]     r_disp;
   logic [CW-1:0]     r_cnt;
   logic              r_ovf;
   logic              r_force;
   logic              r_busy;

   logic [PW-1:0]     r_pre;
   logic [IW-1:0]     r_idx;
   logic [6:0]        r_seg;
   logic [DIGITS-1:0] r_an;
   logic              r_dp;

   logic [BW-1:0]     w_adj;
   logic [3:0]        w_nib;
   logic [6:0]        w_seg;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         DASH:    return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // NOTE: w_adj takes a full default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_last  <= '0;
         r_bcd   <= '0;
         r_disp  <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_force <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (value != r_last || r_force) begin
                  r_shift <= value;
                  r_last  <= value;
                  r_bcd   <= '0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= CW'(WIDTH);
                  r_force <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // A 1 leaving the top nibble means the value needs more digits than we have.
               {r_bcd, r_shift} <= {w_adj[BW-2:0], r_shift, 1'b0};
               if (w_adj[BW-1]) r_ovf <= 1'b1;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_state <= S_DONE;
            end
            S_DONE: begin
               r_disp  <= r_ovf ? {DIGITS{DASH}} : r_bcd;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_nib = r_disp[r_idx*4 +: 4];

`ifdef SEG_DISPLAY_LEAD_BLANK_EN
   logic [DIGITS-1:0] w_zero_above;

   // Bit i is set when digit i and every more significant digit are zero.
   always_comb begin
      w_zero_above = '0;
      w_zero_above[DIGITS-1] = (r_disp[BW-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         w_zero_above[i] = w_zero_above[i+1] && (r_disp[4*i +: 4] == 4'd0);
      end
   end

   assign w_seg = (r_idx != '0 && w_zero_above[r_idx]) ? 7'b1111111 : seg_decode(w_nib);
`else
   assign w_seg = seg_decode(w_nib);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre <= '0;
         r_idx <= '0;
         r_seg <= 7'h7F;
         r_an  <= '1;
         r_dp  <= 1'b1;
      end else begin
         if (r_pre == PW'(REFRESH_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
         r_seg <= w_seg;
         r_an  <= ~(DIGITS'(1) << r_idx);
         r_dp  <= ~dp_in[r_idx];
      end
   end

   assign busy = r_busy;
   assign seg  = r_seg;
   assign an   = r_an;
   assign dp   = r_dp;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: 4 digits, 14-bit input, 4-cycle digit slots.
// Expectations for the blanking scenario follow SEG_DISPLAY_LEAD_BLANK_EN when it is defined.
module tb_seg_display_mux;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000, S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111, SB = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [13:0] value = 14'd1234;
   logic [3:0]  dp_in = 4'b0000;
   logic        busy;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;

   int total = 0;
   int bad = 0;

   logic [6:0] cap_seg [16];
   logic [3:0] cap_an  [16];
   logic       cap_dp  [16];
   logic [6:0] exp_s   [4];

   seg_display_mux #(.DIGITS(4), .WIDTH(14), .REFRESH_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .dp_in (dp_in),
      .busy  (busy),
      .seg   (seg),
      .an    (an),
      .dp    (dp)
   );

   always #5 clk = ~clk;

   // Waits (bounded) for busy, then counts consecutive negedges with busy high.
   task automatic count_busy(output int n);
      int w;
      w = 0;
      n = 0;
      while (busy !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Aligns to the first cycle of slot 0 and records one full 16-cycle frame.
   task automatic capture_frame(output bit found);
      logic [3:0] prev;
      int w;
      found = 1'b0;
      prev = an;
      w = 0;
      while (!found && w < 64) begin
         @(negedge clk);
         w++;
         if (an === 4'b1110 && prev !== 4'b1110) found = 1'b1;
         else prev = an;
      end
      if (found) begin
         for (int j = 0; j < 16; j++) begin
            cap_seg[j] = seg;
            cap_an[j]  = an;
            cap_dp[j]  = dp;
            if (j < 15) @(negedge clk);
         end
      end
   endtask

   task automatic frame_compare(input string name);
      bit found;
      logic [3:0] ea;
      logic ed;
      int slot;
      capture_frame(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL %s_sync: slot 0 start not seen within 64 cycles", name);
      end else begin
         for (int j = 0; j < 16; j++) begin
            slot = j / 4;
            ea = ~(4'b0001 << slot);
            ed = ~dp_in[slot];
            total++;
            if ({cap_seg[j], cap_an[j], cap_dp[j]} !== {exp_s[slot], ea, ed}) begin
               bad++;
               $display("FAIL %s cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                        name, j, cap_seg[j], cap_an[j], cap_dp[j], exp_s[slot], ea, ed);
            end
         end
      end
   endtask

   task automatic busy_compare(input string name, input int n, input int want);
      total++;
      if (n !== want) begin
         bad++;
         $display("FAIL %s: busy cycles got %0d want %0d", name, n, want);
      end
   endtask

   task automatic test_reset;
      int n;
      repeat (3) @(negedge clk);
      total++;
      if ({seg, an, dp, busy} !== {7'h7F, 4'b1111, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_values: got seg=%h an=%b dp=%b busy=%b want seg=7f an=1111 dp=1 busy=0",
                  seg, an, dp, busy);
      end
      reset = 1'b1;
      count_busy(n);
      busy_compare("reset_conv_busy", n, 15);
      exp_s[0] = S4; exp_s[1] = S3; exp_s[2] = S2; exp_s[3] = S1;
      frame_compare("frame_1234");
      frame_compare("frame_1234_repeat");
   endtask

   task automatic test_overflow;
      int n;
      value = 14'd10000;
      count_busy(n);
      busy_compare("ovf_busy", n, 15);
      exp_s[0] = SD; exp_s[1] = SD; exp_s[2] = SD; exp_s[3] = SD;
      frame_compare("frame_10000_dash");
      value = 14'd9999;
      count_busy(n);
      busy_compare("max_busy", n, 15);
      exp_s[0] = S9; exp_s[1] = S9; exp_s[2] = S9; exp_s[3] = S9;
      frame_compare("frame_9999");
   endtask

   task automatic test_back_to_back;
      int n;
      int nlow;
      int n2;
      logic [6:0] es;
      value = 14'd100;
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_start: busy got %b want 1", busy);
      end
      repeat (3) @(negedge clk);
      value = 14'd5;
      count_busy(n);
      busy_compare("b2b_first_busy", n + 3, 15);
      nlow = 0;
      while (busy === 1'b0 && nlow < 40) begin
         nlow++;
         @(negedge clk);
      end
      total++;
      if (nlow !== 1) begin
         bad++;
         $display("FAIL b2b_idle_gap: busy-low cycles got %0d want 1", nlow);
      end
      n2 = 0;
      while (busy === 1'b1 && n2 < 100) begin
         es = (an === 4'b1011) ? S1 : S0;
         total++;
         if (seg !== es) begin
            bad++;
            $display("FAIL b2b_mid_0100: an=%b got seg=%b want %b", an, seg, es);
         end
         n2++;
         @(negedge clk);
      end
      busy_compare("b2b_second_busy", n2, 15);
      exp_s[0] = S5; exp_s[1] = S0; exp_s[2] = S0; exp_s[3] = S0;
      frame_compare("frame_0005");
   endtask

   task automatic test_reset_mid_shift;
      int n;
      value = 14'd1234;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      total++;
      if ({seg, an, dp, busy} !== {7'h7F, 4'b1111, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL async_reset: got seg=%h an=%b dp=%b busy=%b want seg=7f an=1111 dp=1 busy=0",
                  seg, an, dp, busy);
      end
      @(negedge clk);
      reset = 1'b1;
      count_busy(n);
      busy_compare("post_reset_busy", n, 15);
      exp_s[0] = S4; exp_s[1] = S3; exp_s[2] = S2; exp_s[3] = S1;
      frame_compare("frame_after_reset");
   endtask

   task automatic test_dp;
      dp_in = 4'b0100;
      frame_compare("frame_dp_slot2");
      dp_in = 4'b0000;
   endtask

   task automatic test_lead_blank;
      int n;
      value = 14'd7;
      count_busy(n);
      busy_compare("blank7_busy", n, 15);
`ifdef SEG_DISPLAY_LEAD_BLANK_EN
      exp_s[0] = S7; exp_s[1] = SB; exp_s[2] = SB; exp_s[3] = SB;
`else
      exp_s[0] = S7; exp_s[1] = S0; exp_s[2] = S0; exp_s[3] = S0;
`endif
      frame_compare("frame_7");
      value = 14'd0;
      count_busy(n);
      busy_compare("blank0_busy", n, 15);
`ifdef SEG_DISPLAY_LEAD_BLANK_EN
      exp_s[0] = S0; exp_s[1] = SB; exp_s[2] = SB; exp_s[3] = SB;
`else
      exp_s[0] = S0; exp_s[1] = S0; exp_s[2] = S0; exp_s[3] = S0;
`endif
      frame_compare("frame_0");
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_back_to_back();
      test_reset_mid_shift();
      test_dp();
      test_lead_blank();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Parametrised successor to the four-digit binary seven-segment display driver. Converts a `WIDTH`-bit unsigned binary value to BCD with a sequential shift-add-3 engine, holds the result in a display register, and time-multiplexes `DIGITS` common-anode digits from an internal refresh prescaler. Adds over-range indication, per-digit decimal points and optional leading-zero blanking. Sits between switch or counter logic and the board's segment/anode pins.

## Interface

- `DIGITS`, 4, number of displayed digits (1..8).
- `WIDTH`, 14, binary input width (1..27).
- `REFRESH_DIV`, 100000, clk cycles per digit slot (>= 2).

- `clk` in 1, sole clock, rising edge.
- `reset` in 1, asynchronous, active-low (0 = reset).
- `value` in `WIDTH`, unsigned binary to display; need not be synchronous to conversion.
- `dp_in` in `DIGITS`, per-digit decimal point request, 1 = lit; bit i maps to digit i (0 = least significant).
- `busy` out 1, high while a conversion is in progress.
- `seg` out 7, active-low segments, bit0 = a … bit6 = g.
- `an` out `DIGITS`, active-low anode enables, exactly one bit low outside reset.
- `dp` out 1, active-low decimal point.

## Operation

- Conversion FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - Condition for a new conversion: `value` != `last_value`, or the force flag is set.
  - On that condition: capture `value` into the shift register and `last_value`, clear the BCD register (4·`DIGITS` bits) and the overflow flag, set the bit counter to `WIDTH`, clear the force flag, and go to SHIFT.
- SHIFT, one step per cycle:
  - Add 3 to every BCD nibble >= 5.
  - Shift the {BCD, shift register} concatenation left by 1.
  - A 1 shifted out of the top nibble sets the sticky overflow flag.
  - Decrement the counter. Go to DONE after `WIDTH` steps.
- DONE: on overflow, load the display register with the dash code for every digit; otherwise load the BCD result. Return to IDLE.
- `value` changes while the FSM is not in IDLE are ignored until the FSM returns to IDLE. The IDLE comparison then triggers a fresh conversion, so the last stable value always wins.
- Scan logic:
  - Prescaler counts 0..`REFRESH_DIV`-1 and wraps. The wrap cycle is the tick.
  - On a tick, digit index `idx` advances modulo `DIGITS` (wraps `DIGITS`-1 to 0).
- Decode (registered every cycle from `idx` and the display register):
  - BCD 0-9 use the standard active-low codes: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Dash = 0111111.
  - Any other nibble decodes to blank, 1111111.
- Anode output: `an` = ~(1 << `idx`).
- Decimal point output: `dp` = ~`dp_in[idx]`. Decimal points are still driven while overflow dashes are shown.

## Timing

- Reset values:
  - `seg` = 7'h7F, `an` = all ones, `dp` = 1, `busy` = 0.
  - `idx` = 0, prescaler = 0, display register = 0, `last_value` = 0, overflow = 0, FSM = IDLE, force flag = 1.
- Reset is asynchronous. Asserting it mid-conversion aborts the conversion immediately and applies all reset values.
- The first IDLE cycle after reset release always starts a conversion, because the force flag is set.
- Conversion latency:
  - If `value` differs in IDLE at edge k, `busy` is high from edge k for `WIDTH`+1 cycles.
  - The display register updates at edge k+`WIDTH`+1.
  - The new digits appear on `seg` one cycle after that, in whatever slot is active.
- Scan timing:
  - `seg`, `an` and `dp` are registered and change together one cycle after the tick or after a display register update.
  - Each digit is held for exactly `REFRESH_DIV` cycles.
  - One full refresh frame is `DIGITS`·`REFRESH_DIV` cycles.
- Scan and conversion run independently; conversion never stalls the scan.

## Configuration

- `SEG_DISPLAY_LEAD_BLANK_EN`:
  - When defined, leading-zero blanking is enabled. Digit i > 0 is driven blank (1111111) when it and every higher digit are 0. Digit 0 is never blanked. Blanking does not apply in the overflow state.
  - When undefined, all digits are always shown, including leading zeros.
  - `dp` is unaffected either way.

## Test plan

Bench uses `DIGITS`=4, `WIDTH`=14, `REFRESH_DIV`=4, macro undefined unless stated.

- Reset release with `value`=1234 -> `busy`=1 for 15 cycles. Then `an`=1110/`seg`=0011001, `an`=1101/0110000, `an`=1011/0100100, `an`=0111/1111001, each held 4 cycles, then the frame repeats.
- `value`=10000 -> after conversion, all four slots show `seg`=0111111. `value`=9999 -> all slots show 0010000.
- `value`=100, then changed to 5 three cycles into SHIFT -> the first conversion completes with 0100. A second conversion follows immediately. The display ends at 0005, with `busy` low for exactly one IDLE cycle between the two conversions.
- `reset` pulled low during SHIFT -> `seg`=7F, `an`=1111, `dp`=1, `busy`=0 in the same cycle with no clock. After release, a forced conversion of the current `value` runs.
- `dp_in`=0100 -> `dp`=0 only in slots where `an`=1011; `dp`=1 elsewhere.
- Macro defined, `value`=7 -> `an`=1110 shows 1111000 and the other three slots show 1111111. `value`=0 -> slot 0 shows 1000000 and the rest are blank.
